vend_controller: RTL and testbench

Sequencing controller for the vending machine. It takes the 3-digit item code from the keypad block, fetches the item price from the shared price table, and accumulates coin credit. It then drives the dispenser and returns change. It gates the keypad through `busy` and `clear` and is the sole master of the price-table and dispenser handshakes.

---
 rtl/vend_controller.sv | 196 +++++++++++++++++++
 tb/tb_vend_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Vending machine sequencer: item price lookup, coin credit accumulation,
// dispenser handshake and change return. All outputs are registered.
module vend_controller #(
  parameter int CREDIT_W = 12,
  parameter int TIMEOUT  = 1000,
  parameter int ERR_HOLD = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_check_price,
  input  logic [11:0]         i_concat_press,
  input  logic                i_coin_valid,
  input  logic [7:0]          i_coin_value,
  input  logic                i_cancel,
  input  logic                i_price_ready,
  input  logic                i_price_found,
  input  logic [CREDIT_W-1:0] i_price_data,
  input  logic                i_dispense_done,
  output logic                o_busy,
  output logic                o_clear,
  output logic                o_price_req,
  output logic [11:0]         o_item_code,
  output logic                o_dispense_req,
  output logic                o_change_valid,
  output logic [CREDIT_W-1:0] o_change_amount,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_error
);

  // state     | meaning
  // S_IDLE    | waiting for a complete item code; coins and cancel accepted
  // S_LOOKUP  | price request outstanding
  // S_WAIT    | price known, collecting coins until paid, cancel or timeout
  // S_DISPENSE| dispense request outstanding
  // S_CHANGE  | one cycle: return remaining credit, clear keypad
  // S_ERROR   | unknown item, hold error before refunding
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WAIT, S_DISPENSE, S_CHANGE, S_ERROR
  } state_t;

  localparam int TMO_W = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
  localparam int ERR_W = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;
  localparam int SUM_W = CREDIT_W + 9;
  localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'({CREDIT_W{1'b1}});

  state_t              r_state, w_state_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_clear, w_clear_nxt;
  logic                r_price_req, w_price_req_nxt;
  logic [11:0]         r_item_code, w_item_code_nxt;
  logic                r_dispense_req, w_dispense_req_nxt;
  logic                r_change_valid, w_change_valid_nxt;
  logic [CREDIT_W-1:0] r_change_amount, w_change_amount_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [CREDIT_W-1:0] r_price, w_price_nxt;
  logic                r_error, w_error_nxt;
  logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
  logic [ERR_W-1:0]    r_err_cnt, w_err_cnt_nxt;

  logic [SUM_W-1:0]    w_sum;
  logic [CREDIT_W-1:0] w_credit_add;
  logic                w_coin_ok;

  // Saturating credit addition; coins only count before dispensing starts
  always_comb begin
    w_sum        = SUM_W'(r_credit) + SUM_W'(i_coin_value);
    w_credit_add = (w_sum > CREDIT_MAX) ? {CREDIT_W{1'b1}} : w_sum[CREDIT_W-1:0];
    w_coin_ok    = i_coin_valid &&
                   (r_state == S_IDLE || r_state == S_LOOKUP || r_state == S_WAIT);
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt         = r_state;
    w_busy_nxt          = r_busy;
    w_clear_nxt         = 1'b0;
    w_price_req_nxt     = r_price_req;
    w_item_code_nxt     = r_item_code;
    w_dispense_req_nxt  = r_dispense_req;
    w_change_valid_nxt  = 1'b0;
    w_change_amount_nxt = r_change_amount;
    w_credit_nxt        = w_coin_ok ? w_credit_add : r_credit;
    w_price_nxt         = r_price;
    w_tmo_nxt           = r_tmo;
    w_err_cnt_nxt       = r_err_cnt;

    case (r_state)
      S_IDLE: begin
        w_busy_nxt = i_check_price;
        if (i_check_price) begin
          w_item_code_nxt = i_concat_press;
          w_price_req_nxt = 1'b1;
          w_state_nxt     = S_LOOKUP;
        end else if (i_cancel) begin
          w_state_nxt = S_CHANGE;
        end
      end
      S_LOOKUP: begin
        w_busy_nxt = 1'b1;
        if (i_price_ready) begin
          w_price_req_nxt = 1'b0;
          if (i_price_found) begin
            w_price_nxt = i_price_data;
            w_tmo_nxt   = '0;
            w_state_nxt = S_WAIT;
          end else begin
            w_err_cnt_nxt = '0;
            w_state_nxt   = S_ERROR;
          end
        end
      end
      S_WAIT: begin
        w_busy_nxt = 1'b1;
        w_tmo_nxt  = i_coin_valid ? '0 : r_tmo + TMO_W'(1);
        if (r_credit >= r_price) begin
          w_dispense_req_nxt = 1'b1;
          w_state_nxt        = S_DISPENSE;
        end else if (i_cancel) begin
          w_state_nxt = S_CHANGE;
        end else if (!i_coin_valid && r_tmo == TMO_W'(TIMEOUT - 1)) begin
          w_state_nxt = S_CHANGE;
        end
      end
      S_DISPENSE: begin
        w_busy_nxt = 1'b1;
        if (i_dispense_done) begin
          w_dispense_req_nxt = 1'b0;
          w_credit_nxt       = r_credit - r_price;
          w_state_nxt        = S_CHANGE;
        end
      end
      S_CHANGE: begin
        // busy keeps its value so it only drops once IDLE is reached
        if (r_credit != '0) begin
          w_change_valid_nxt  = 1'b1;
          w_change_amount_nxt = r_credit;
        end
        w_credit_nxt = '0;
        w_clear_nxt  = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      S_ERROR: begin
        w_busy_nxt    = 1'b1;
        w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
        if (r_err_cnt == ERR_W'(ERR_HOLD - 1)) w_state_nxt = S_CHANGE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_error_nxt = (w_state_nxt == S_ERROR);
  end

  // State and output registers; reset aborts any handshake and drops credit
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state         <= S_IDLE;
      r_busy          <= 1'b0;
      r_clear         <= 1'b0;
      r_price_req     <= 1'b0;
      r_item_code     <= '0;
      r_dispense_req  <= 1'b0;
      r_change_valid  <= 1'b0;
      r_change_amount <= '0;
      r_credit        <= '0;
      r_price         <= '0;
      r_error         <= 1'b0;
      r_tmo           <= '0;
      r_err_cnt       <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_busy          <= w_busy_nxt;
      r_clear         <= w_clear_nxt;
      r_price_req     <= w_price_req_nxt;
      r_item_code     <= w_item_code_nxt;
      r_dispense_req  <= w_dispense_req_nxt;
      r_change_valid  <= w_change_valid_nxt;
      r_change_amount <= w_change_amount_nxt;
      r_credit        <= w_credit_nxt;
      r_price         <= w_price_nxt;
      r_error         <= w_error_nxt;
      r_tmo           <= w_tmo_nxt;
      r_err_cnt       <= w_err_cnt_nxt;
    end
  end

  assign o_busy          = r_busy;
  assign o_clear         = r_clear;
  assign o_price_req     = r_price_req;
  assign o_item_code     = r_item_code;
  assign o_dispense_req  = r_dispense_req;
  assign o_change_valid  = r_change_valid;
  assign o_change_amount = r_change_amount;
  assign o_credit        = r_credit;
  assign o_error         = r_error;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios plus randomized purchases,
// checked against a transaction-level credit model.
module tb_vend_controller;
  localparam int CW   = 12;
  localparam int TMO  = 16;
  localparam int EH   = 4;
  localparam int MAXC = 4095;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          check_price, coin_valid, cancel, price_ready, price_found, dispense_done;
  logic [11:0]   concat_press;
  logic [7:0]    coin_value;
  logic [CW-1:0] price_data;
  logic          busy, clr, price_req, dispense_req, change_valid, err;
  logic [11:0]   item_code;
  logic [CW-1:0] change_amount, credit;

  int checks = 0;
  int errors = 0;
  int m_credit = 0;

  vend_controller #(.CREDIT_W(CW), .TIMEOUT(TMO), .ERR_HOLD(EH)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_check_price(check_price),
    .i_concat_press(concat_press), .i_coin_valid(coin_valid), .i_coin_value(coin_value),
    .i_cancel(cancel), .i_price_ready(price_ready), .i_price_found(price_found),
    .i_price_data(price_data), .i_dispense_done(dispense_done),
    .o_busy(busy), .o_clear(clr), .o_price_req(price_req), .o_item_code(item_code),
    .o_dispense_req(dispense_req), .o_change_valid(change_valid),
    .o_change_amount(change_amount), .o_credit(credit), .o_error(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int sat(input int a, input int b);
    return (a + b > MAXC) ? MAXC : a + b;
  endfunction

  function automatic int pick_coin();
    case ($urandom_range(0, 4))
      0: return 5;
      1: return 10;
      2: return 25;
      3: return 50;
      default: return 100;
    endcase
  endfunction

  task automatic coin(input int v);
    coin_valid = 1'b1;
    coin_value = 8'(v);
    tick();
    coin_valid = 1'b0;
    m_credit = sat(m_credit, v);
    chk("credit_after_coin", 32'(credit), m_credit);
  endtask

  task automatic start(input logic [11:0] code);
    check_price  = 1'b1;
    concat_press = code;
    tick();
    check_price = 1'b0;
    chk("busy_on_start", 32'(busy), 1);
    chk("price_req_on_start", 32'(price_req), 1);
    chk("item_code_latched", 32'(item_code), 32'(code));
  endtask

  task automatic lookup(input bit found, input int price);
    repeat ($urandom_range(0, 3)) tick();
    chk("price_req_held", 32'(price_req), 1);
    price_ready = 1'b1;
    price_found = found;
    price_data  = CW'(price);
    tick();
    price_ready = 1'b0;
    chk("price_req_dropped", 32'(price_req), 0);
    chk("error_after_lookup", 32'(err), found ? 0 : 1);
  endtask

  // Called with the DUT sitting in its change-return cycle
  task automatic finish_change(input int amt);
    tick();
    chk("change_valid", 32'(change_valid), (amt != 0) ? 1 : 0);
    if (amt != 0) chk("change_amount", 32'(change_amount), amt);
    chk("clear_pulse", 32'(clr), 1);
    chk("credit_zero_after_change", 32'(credit), 0);
    tick();
    chk("busy_idle", 32'(busy), 0);
    chk("clear_one_cycle", 32'(clr), 0);
    chk("change_valid_one_cycle", 32'(change_valid), 0);
    m_credit = 0;
  endtask

  task automatic pay(input int price, input logic [11:0] code);
    int guard = 0;
    while (m_credit < price && guard < 100) begin
      repeat ($urandom_range(0, 2)) tick();
      coin(pick_coin());
      chk("no_early_dispense", 32'(dispense_req), 0);
      guard++;
    end
    tick();
    chk("dispense_req_rise", 32'(dispense_req), 1);
    chk("dispense_item_code", 32'(item_code), 32'(code));
  endtask

  task automatic dispense(input int price);
    repeat ($urandom_range(0, 3)) tick();
    chk("dispense_req_held", 32'(dispense_req), 1);
    dispense_done = 1'b1;
    tick();
    dispense_done = 1'b0;
    m_credit = m_credit - price;
    chk("dispense_req_dropped", 32'(dispense_req), 0);
    chk("credit_after_dispense", 32'(credit), m_credit);
    finish_change(m_credit);
  endtask

  initial begin
    int n;
    int price;
    logic [11:0] code;

    rst_n = 1'b0;
    check_price = 0; coin_valid = 0; cancel = 0; price_ready = 0;
    price_found = 0; dispense_done = 0;
    concat_press = '0; coin_value = '0; price_data = '0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_price_req", 32'(price_req), 0);
    chk("rst_dispense_req", 32'(dispense_req), 0);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_item_code", 32'(item_code), 0);
    chk("rst_error", 32'(err), 0);
    chk("rst_clear", 32'(clr), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Code 0x123, price 150, two 100-cent coins: change of 50
    start(12'h123);
    lookup(1'b1, 150);
    coin(100);
    coin(100);
    tick();
    chk("dispense_req_0x123", 32'(dispense_req), 1);
    chk("item_code_0x123", 32'(item_code), 32'h123);
    dispense(150);

    // Unknown item with a coin entered alongside the code: error hold then refund
    check_price  = 1'b1;
    concat_press = 12'h9F0;
    coin_valid   = 1'b1;
    coin_value   = 8'd25;
    tick();
    check_price = 1'b0;
    coin_valid  = 1'b0;
    m_credit = 25;
    chk("busy_with_coin", 32'(busy), 1);
    chk("credit_with_code", 32'(credit), m_credit);
    lookup(1'b0, 0);
    n = 0;
    while (err && n < 20) begin
      chk("no_dispense_in_error", 32'(dispense_req), 0);
      tick();
      n++;
    end
    chk("error_hold_cycles", n, EH);
    finish_change(25);

    // Cancel in WAIT_COIN; a new code entered meanwhile is ignored
    start(12'h456);
    lookup(1'b1, 200);
    coin(50);
    check_price  = 1'b1;
    concat_press = 12'h789;
    tick();
    check_price = 1'b0;
    chk("code_ignored_in_wait", 32'(item_code), 32'h456);
    chk("busy_in_wait", 32'(busy), 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("no_dispense_on_cancel", 32'(dispense_req), 0);
    finish_change(50);

    // Timeout with no coins: change cycle after TIMEOUT cycles, nothing refunded
    start(12'h321);
    lookup(1'b1, 100);
    n = 0;
    while (!clr && n < 4 * TMO) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, TMO + 1);
    chk("timeout_no_change", 32'(change_valid), 0);
    chk("timeout_no_dispense", 32'(dispense_req), 0);
    tick();
    chk("timeout_busy_idle", 32'(busy), 0);

    // Credit saturation from coins inserted in IDLE, refunded by cancel
    repeat (17) coin(255);
    chk("credit_saturated", 32'(credit), MAXC);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    finish_change(MAXC);

    // Reset while dispensing drops everything at once
    start(12'h555);
    lookup(1'b1, 30);
    pay(30, 12'h555);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dispense_req", 32'(dispense_req), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_credit", 32'(credit), 0);
    m_credit = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 0);

    // Randomized purchases, including a free item and some pre-inserted credit
    for (int i = 0; i < 8; i++) begin
      code  = 12'($urandom);
      price = (i == 0) ? 0 : 5 * $urandom_range(0, 60);
      repeat ($urandom_range(0, 2)) coin(pick_coin());
      start(code);
      lookup(1'b1, price);
      pay(price, code);
      dispense(price);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
